add_pipe: RTL

- Parametrised, pipelined successor to the team's combinational 64-bit adder.
- Splits a WIDTH-bit add into STAGES carry-chain segments with registered carries between them, so the datapath sits between clk-domain registers at higher fmax.
- Full valid/ready handshake on both sides, carry-in/carry-out, global-stall pipeline.
- Sits between operand-producing logic and any downstream consumer that can apply backpressure.

---
 rtl/add_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder split into STAGES carry-chain segments.
// Each stage adds one SEG-bit segment plus the carry registered by the stage
// before it. Operands not yet consumed travel forward with the partial sum, so
// every segment of one transaction leaves the last stage together.
// The whole pipeline advances or holds as one unit. When the output holds a
// valid result that is not taken, every stage stalls and bubbles are not
// squeezed out.
//
// Optional build macro: ADD_PIPE_OVF_EN adds the ovf output. ovf reports
// signed two's-complement overflow of the result.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   a, b       operands, sampled on the input handshake
//   cin        carry-in to bit 0
//   in_valid   operands valid
//   in_ready   the pipeline can take operands this cycle (combinational)
//   q          sum a+b+cin mod 2^WIDTH (registered)
//   cout       carry out of bit WIDTH-1 (registered)
//   out_valid  q/cout valid (registered)
//   out_ready  the consumer takes the result this cycle
//   ovf        signed overflow flag (only with ADD_PIPE_OVF_EN, registered)
module add_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Reject configurations that cannot be divided into equal segments.
  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  // Stage k output register: the low (k+1) segments hold the sum and the upper
  // segments still hold operand a. bop_q carries operand b alongside it.
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  bop_q [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;

  // Stage inputs. Stage 0 reads the ports; stage k reads register k-1.
  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [STAGES-1:0] c_s;
  logic [SEG:0]      seg_sum;

  logic adv;

  // Global advance: move when the output slot is empty or is being taken.
  assign adv      = ~v_q[LAST] | out_ready;
  assign in_ready = adv;

  // Per-stage segment add and next-state values.
  always_comb begin : stage_comb
    seg_sum = '0;
    v_d     = '0;
    c_d     = '0;
    c_s     = '0;
    a_s[0]  = a;
    b_s[0]  = b;
    c_s[0]  = cin;
    v_d[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_s[k] = acc_q[k-1];
      b_s[k] = bop_q[k-1];
      c_s[k] = c_q[k-1];
      v_d[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_sum  = {1'b0, a_s[k][k*SEG +: SEG]} + {1'b0, b_s[k][k*SEG +: SEG]}
               + (SEG+1)'(c_s[k]);
      acc_d[k] = a_s[k];
      acc_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k]   = seg_sum[SEG];
    end
  end

  // Pipeline registers. All stages hold together when adv is low.
  always_ff @(posedge clk or negedge reset) begin : stage_regs
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        bop_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        bop_q[k] <= b_s[k];
      end
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign q         = acc_q[LAST];
  assign cout      = c_q[LAST];
  assign out_valid = v_q[LAST];

`ifdef ADD_PIPE_OVF_EN
  // The top segment is added in the last stage. Its inputs still hold the
  // original operand sign bits.
  logic ovf_d, ovf_q;

  assign ovf_d = (a_s[LAST][WIDTH-1] == b_s[LAST][WIDTH-1]) &&
                 (acc_d[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);

  always_ff @(posedge clk or negedge reset) begin : ovf_reg
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
